// File: rtl/jt007232_romarb_if.sv
`default_nettype none
// ============================================================================
// Module      : jt007232_romarb_if
// Description : Bundle of the two client channels and the shared ROM port
//               served by jt007232_romarb.
// Revision    : 1.0 - initial release
// ============================================================================
interface jt007232_romarb_if;
  // Cache flush strobe
  logic        inval;
  // Channel A client side
  logic [16:0] cha_addr;
  logic        cha_cs;
  logic [7:0]  cha_dout;
  logic        cha_ok;
  // Channel B client side
  logic [16:0] chb_addr;
  logic        chb_cs;
  logic [7:0]  chb_dout;
  logic        chb_ok;
  // Shared ROM side
  logic [16:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_dout;
  logic        rom_ok;

  // Environment view: issues channel requests and answers as the ROM
  modport master (
    output inval, cha_addr, cha_cs, chb_addr, chb_cs, rom_dout, rom_ok,
    input  cha_dout, cha_ok, chb_dout, chb_ok, rom_addr, rom_cs
  );

  // Arbiter view
  modport slave (
    input  inval, cha_addr, cha_cs, chb_addr, chb_cs, rom_dout, rom_ok,
    output cha_dout, cha_ok, chb_dout, chb_ok, rom_addr, rom_cs
  );
endinterface
`default_nettype wire

// File: rtl/jt007232_romarb.sv
`default_nettype none
// ============================================================================
// Module      : jt007232_romarb
// Description : Two-channel ROM arbiter with a single-entry byte cache per
//               channel. Hits answer in the same cycle; misses are fetched
//               one at a time through a shared registered ROM port.
// Revision    : 1.0 - initial release
// ============================================================================
module jt007232_romarb #(
  parameter int FIXED_PRIO = 0   // 0: round-robin on ties, 1: channel A wins ties
) (
  input wire              clk,
  input wire              rst_n,
  jt007232_romarb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } state_t;

  state_t      state;
  logic        settled;      // low during the first BUSY cycle, when rom_ok may be stale
  logic        last_b;       // 1: channel B was served last
  logic [16:0] rom_addr_r;
  logic        rom_cs_r;

  logic        valid_a, valid_b;
  logic [16:0] tag_a, tag_b;
  logic [7:0]  data_a, data_b;

  logic hit_a, hit_b;
  logic pend_a, pend_b;
  logic tie_to_b;
  logic grant_a, grant_b;
  logic fill_a, fill_b;

  // Cache lookup, request arbitration and fill qualification
  always_comb begin
    hit_a    = bus.cha_cs & valid_a & (tag_a == bus.cha_addr);
    hit_b    = bus.chb_cs & valid_b & (tag_b == bus.chb_addr);
    pend_a   = bus.cha_cs & ~hit_a;
    pend_b   = bus.chb_cs & ~hit_b;
    // On a tie, round-robin hands the grant to whoever was not served last
    tie_to_b = (FIXED_PRIO == 0) && !last_b;
    grant_a  = pend_a & (~pend_b | ~tie_to_b);
    grant_b  = pend_b & ~grant_a;
    fill_a   = (state == BUSY_A) & settled & bus.rom_ok;
    fill_b   = (state == BUSY_B) & settled & bus.rom_ok;
  end

  assign bus.cha_ok   = hit_a;
  assign bus.cha_dout = data_a;
  assign bus.chb_ok   = hit_b;
  assign bus.chb_dout = data_b;
  assign bus.rom_addr = rom_addr_r;
  assign bus.rom_cs   = rom_cs_r;

  // Transaction sequencer: one ROM access at a time, address latched at grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settled    <= 1'b0;
      last_b     <= 1'b1;
      rom_addr_r <= 17'd0;
      rom_cs_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          settled <= 1'b0;
          if (grant_a) begin
            rom_addr_r <= bus.cha_addr;
            rom_cs_r   <= 1'b1;
            state      <= BUSY_A;
          end else if (grant_b) begin
            rom_addr_r <= bus.chb_addr;
            rom_cs_r   <= 1'b1;
            state      <= BUSY_B;
          end
        end
        BUSY_A, BUSY_B: begin
          settled <= 1'b1;
          if (fill_a | fill_b) begin
            // Return through IDLE so the next grant sees the updated cache
            rom_cs_r <= 1'b0;
            last_b   <= (state == BUSY_B);
            settled  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          rom_cs_r <= 1'b0;
          settled  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Cache entries: filled from the latched ROM address; a flush wins over a fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      tag_a   <= 17'd0;
      tag_b   <= 17'd0;
      data_a  <= 8'd0;
      data_b  <= 8'd0;
    end else if (bus.inval) begin
      valid_a <= 1'b0;
      valid_b <= 1'b0;
    end else begin
      if (fill_a) begin
        valid_a <= 1'b1;
        tag_a   <= rom_addr_r;
        data_a  <= bus.rom_dout;
      end
      if (fill_b) begin
        valid_b <= 1'b1;
        tag_b   <= rom_addr_r;
        data_b  <= bus.rom_dout;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jt007232_romarb.sv
`default_nettype none
// ============================================================================
// Module      : tb_jt007232_romarb
// Description : Self-checking bench for jt007232_romarb: directed vector
//               table, hand-written corner sequences and a randomized run
//               against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jt007232_romarb;

  localparam int FP = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jt007232_romarb_if bus ();

  jt007232_romarb #(.FIXED_PRIO(FP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ROM contents: a fixed scramble of the address
  function automatic logic [7:0] rom_byte(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h4A;
  endfunction

  assign bus.rom_dout = rom_byte(bus.rom_addr);

  // Stimulus registers
  logic        cs   [2];
  logic [16:0] addr [2];
  logic        rok;
  logic        inv;

  // Behavioural model: cache per channel plus the one outstanding fetch
  logic        m_valid [2];
  logic [16:0] m_tag   [2];
  logic [7:0]  m_data  [2];
  int          m_busy;     // -1 idle, else channel being fetched
  int          m_age;      // cycles already spent on the fetch
  logic [16:0] m_raddr;
  int          m_last;     // channel served last

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int x = 0; x < 2; x++) begin
      m_valid[x] = 1'b0;
      m_tag[x]   = 17'd0;
      m_data[x]  = 8'd0;
    end
    m_busy  = -1;
    m_age   = 0;
    m_raddr = 17'd0;
    m_last  = 1;
  endtask

  task automatic drive();
    bus.cha_cs   = cs[0];
    bus.cha_addr = addr[0];
    bus.chb_cs   = cs[1];
    bus.chb_addr = addr[1];
    bus.rom_ok   = rok;
    bus.inval    = inv;
  endtask

  // One clock: drive, compare at negedge against the model, advance the model
  task automatic cycle();
    logic h [2];
    logic pa, pb;
    int   g;
    drive();
    @(negedge clk);
    for (int x = 0; x < 2; x++)
      h[x] = cs[x] && m_valid[x] && (m_tag[x] == addr[x]);
    check("cha_ok",   32'(bus.cha_ok),   32'(h[0]));
    check("chb_ok",   32'(bus.chb_ok),   32'(h[1]));
    check("cha_dout", 32'(bus.cha_dout), 32'(m_data[0]));
    check("chb_dout", 32'(bus.chb_dout), 32'(m_data[1]));
    check("rom_cs",   32'(bus.rom_cs),   32'(m_busy >= 0));
    check("rom_addr", 32'(bus.rom_addr), 32'(m_raddr));
    if (m_busy >= 0) begin
      if (m_age >= 1 && rok) begin
        if (!inv) begin
          m_valid[m_busy] = 1'b1;
          m_tag[m_busy]   = m_raddr;
          m_data[m_busy]  = rom_byte(m_raddr);
        end
        m_last = m_busy;
        m_busy = -1;
      end else begin
        m_age++;
      end
    end else begin
      pa = cs[0] && !h[0];
      pb = cs[1] && !h[1];
      if (pa && pb) g = (FP == 1 || m_last == 1) ? 0 : 1;
      else if (pa)  g = 0;
      else if (pb)  g = 1;
      else          g = -1;
      if (g >= 0) begin
        m_busy  = g;
        m_raddr = addr[g];
        m_age   = 0;
      end
    end
    if (inv) begin
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int x = 0; x < 2; x++) begin
      cs[x]   = 1'b0;
      addr[x] = 17'd0;
    end
    rok = 1'b0;
    inv = 1'b0;
    drive();
    model_reset();
    @(negedge clk);
    check("rst_cha_ok",   32'(bus.cha_ok),   32'd0);
    check("rst_chb_ok",   32'(bus.chb_ok),   32'd0);
    check("rst_cha_dout", 32'(bus.cha_dout), 32'd0);
    check("rst_chb_dout", 32'(bus.chb_dout), 32'd0);
    check("rst_rom_cs",   32'(bus.rom_cs),   32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          csa;
    logic [16:0] aa;
    bit          csb;
    logic [16:0] ab;
    bit          rok;
    bit          inv;
    bit          oka;
    bit          okb;
    bit          rcs;
    logic [16:0] raddr;
    logic [7:0]  da;
    logic [7:0]  db;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // Single miss, hit, B miss, flush while both hit, refetch A then B,
    // flush colliding with B's fill
    tbl[0]  = '{1, 17'h10, 0, 17'h00, 0, 0, 0, 0, 0, 17'h00, 8'h00, 8'h00};
    tbl[1]  = '{1, 17'h10, 0, 17'h00, 1, 0, 0, 0, 1, 17'h10, 8'h00, 8'h00};
    tbl[2]  = '{1, 17'h10, 0, 17'h00, 1, 0, 0, 0, 1, 17'h10, 8'h00, 8'h00};
    tbl[3]  = '{1, 17'h10, 0, 17'h00, 0, 0, 1, 0, 0, 17'h10, 8'h5A, 8'h00};
    tbl[4]  = '{1, 17'h10, 0, 17'h00, 0, 0, 1, 0, 0, 17'h10, 8'h5A, 8'h00};
    tbl[5]  = '{1, 17'h10, 1, 17'h20, 0, 0, 1, 0, 0, 17'h10, 8'h5A, 8'h00};
    tbl[6]  = '{1, 17'h10, 1, 17'h20, 0, 0, 1, 0, 1, 17'h20, 8'h5A, 8'h00};
    tbl[7]  = '{1, 17'h10, 1, 17'h20, 0, 0, 1, 0, 1, 17'h20, 8'h5A, 8'h00};
    tbl[8]  = '{1, 17'h10, 1, 17'h20, 1, 0, 1, 0, 1, 17'h20, 8'h5A, 8'h00};
    tbl[9]  = '{1, 17'h10, 1, 17'h20, 0, 1, 1, 1, 0, 17'h20, 8'h5A, 8'h6A};
    tbl[10] = '{1, 17'h10, 1, 17'h20, 0, 0, 0, 0, 0, 17'h20, 8'h5A, 8'h6A};
    tbl[11] = '{1, 17'h10, 1, 17'h20, 1, 0, 0, 0, 1, 17'h10, 8'h5A, 8'h6A};
    tbl[12] = '{1, 17'h10, 1, 17'h20, 1, 0, 0, 0, 1, 17'h10, 8'h5A, 8'h6A};
    tbl[13] = '{1, 17'h10, 1, 17'h20, 0, 0, 1, 0, 0, 17'h10, 8'h5A, 8'h6A};
    tbl[14] = '{1, 17'h10, 1, 17'h20, 0, 0, 1, 0, 1, 17'h20, 8'h5A, 8'h6A};
    tbl[15] = '{1, 17'h10, 1, 17'h20, 1, 1, 1, 0, 1, 17'h20, 8'h5A, 8'h6A};
    tbl[16] = '{1, 17'h10, 1, 17'h20, 0, 0, 0, 0, 0, 17'h20, 8'h5A, 8'h6A};
    tbl[17] = '{1, 17'h10, 1, 17'h20, 0, 0, 0, 0, 1, 17'h10, 8'h5A, 8'h6A};

    // ---------------- directed vector table ----------------
    do_reset();
    for (int i = 0; i < 18; i++) begin
      cs[0] = tbl[i].csa;  addr[0] = tbl[i].aa;
      cs[1] = tbl[i].csb;  addr[1] = tbl[i].ab;
      rok   = tbl[i].rok;  inv     = tbl[i].inv;
      drive();
      @(negedge clk);
      check($sformatf("vec%0d_cha_ok", i), 32'(bus.cha_ok), 32'(tbl[i].oka));
      check($sformatf("vec%0d_chb_ok", i), 32'(bus.chb_ok), 32'(tbl[i].okb));
      check($sformatf("vec%0d_rom_cs", i), 32'(bus.rom_cs), 32'(tbl[i].rcs));
      if (tbl[i].rcs)
        check($sformatf("vec%0d_rom_addr", i), 32'(bus.rom_addr), 32'(tbl[i].raddr));
      if (tbl[i].oka)
        check($sformatf("vec%0d_cha_dout", i), 32'(bus.cha_dout), 32'(tbl[i].da));
      if (tbl[i].okb)
        check($sformatf("vec%0d_chb_dout", i), 32'(bus.chb_dout), 32'(tbl[i].db));
      @(posedge clk);
      #1;
    end

    // ---------------- simultaneous misses, round-robin ----------------
    do_reset();
    cs[0] = 1'b1; addr[0] = 17'h100;
    cs[1] = 1'b1; addr[1] = 17'h200;
    rok = 1'b1;                               // held high: settle cycle must be ignored
    cycle();
    check("tie_first_a", 32'(bus.rom_addr), 32'h100);
    cycle();
    cycle();
    check("tie_fill_a_cs", 32'(bus.rom_cs), 32'd0);
    addr[0] = 17'h101;                        // A misses again alongside B
    cycle();
    check("tie_then_b", 32'(bus.rom_addr), 32'h200);
    cycle();
    cycle();
    cycle();
    check("tie_back_to_a", 32'(bus.rom_addr), 32'h101);
    for (int i = 0; i < 4; i++) cycle();

    // ---------------- reset during BUSY_B ----------------
    do_reset();
    cs[1] = 1'b1; addr[1] = 17'h1_0033;
    cycle();
    cycle();
    check("busy_b_cs", 32'(bus.rom_cs), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rom_cs", 32'(bus.rom_cs), 32'd0);
    check("midrst_chb_ok", 32'(bus.chb_ok), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rok = 1'b1;
    cycle();
    cycle();
    check("reissue_cs",   32'(bus.rom_cs),   32'd1);
    check("reissue_addr", 32'(bus.rom_addr), 32'h1_0033);
    for (int i = 0; i < 4; i++) cycle();
    check("reissue_hit", 32'(bus.chb_ok), 32'd1);

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int x = 0; x < 2; x++) begin
        if ($urandom % 8 == 0) cs[x] = ($urandom % 4) != 0;
        if ($urandom % 6 == 0)
          addr[x] = (x == 0 ? 17'h0_1000 : 17'h1_FFF0) + 17'($urandom % 4);
      end
      rok = ($urandom % 3) != 0;
      inv = ($urandom % 40) == 0;
      if ($urandom % 900 == 0) do_reset();
      else cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jt007232_romarb.md
JT007232_ROMARB -- requirements
Module: jt007232_romarb

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin between channels, 1 = channel A always wins a tie.
REQ-002 SHALL have port clk, input, 1 bit; the single system clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-004 SHALL have port inval, input, 1 bit; a one-cycle pulse that invalidates both channel caches.
REQ-005 SHALL have ports cha_addr and chb_addr, input, 17 bits each; per-channel ROM byte address.
REQ-006 SHALL have ports cha_cs and chb_cs, input, 1 bit each; per-channel read request, level-sensitive.
REQ-007 SHALL have ports cha_dout and chb_dout, output, 8 bits each; per-channel cached data byte.
REQ-008 SHALL have ports cha_ok and chb_ok, output, 1 bit each; per-channel data valid for the current address.
REQ-009 SHALL have port rom_addr, output, 17 bits; shared ROM address, registered.
REQ-010 SHALL have port rom_cs, output, 1 bit; shared ROM request, registered.
REQ-011 SHALL have port rom_dout, input, 8 bits; shared ROM data.
REQ-012 SHALL have port rom_ok, input, 1 bit; shared ROM data valid.

Function
REQ-013 SHALL keep one cache entry per channel (valid, 17-bit tag, 8-bit data): hit_x = x_cs & valid_x & (tag_x == x_addr).
REQ-014 SHALL drive x_ok = hit_x and x_dout = data_x combinationally from registers, with zero-cycle latency on a hit.
REQ-015 SHALL treat channel x as pending when x_cs is high and hit_x is low.
REQ-016 SHALL implement FSM states IDLE, BUSY_A, BUSY_B.
REQ-017 In IDLE, when exactly one channel is pending, SHALL grant that channel, register rom_addr <= x_addr and rom_cs <= 1, and go to BUSY_x.
REQ-018 In IDLE, when both channels are pending:
- FIXED_PRIO=1: SHALL grant A.
- FIXED_PRIO=0: SHALL grant the channel not recorded as last_served.
REQ-019 In BUSY_x, SHALL ignore rom_ok on the first cycle (settle cycle) and sample rom_ok from the second cycle onward.
REQ-020 In BUSY_x, on the edge where sampled rom_ok is high, SHALL:
- write tag_x <= rom_addr, data_x <= rom_dout, valid_x <= 1;
- set rom_cs <= 0 and last_served <= x;
- return to IDLE.
REQ-021 Miss latency: miss visible at cycle N, rom_cs high at N+1, earliest fill at the end of N+2, x_ok high at N+3 if the address is unchanged.
REQ-022 SHALL hold rom_addr constant for the whole BUSY state, whatever x_addr does.
REQ-023 If x_cs drops or x_addr changes during BUSY_x, SHALL still complete the transaction and fill the cache with the latched address; a changed address then misses and is re-requested from IDLE.
REQ-024 SHALL not grant a new request in the same cycle as a fill; IDLE lasts at least one cycle between transactions.
REQ-025 A non-granted pending channel SHALL wait with x_ok low, and SHALL be served next when both channels are pending (no starvation under FIXED_PRIO=0).
REQ-026 inval SHALL clear valid_a and valid_b on the next edge, leaving tags and data unchanged.
REQ-027 A fill coinciding with inval SHALL be discarded (valid stays 0); the FSM still returns to IDLE.
REQ-028 inval SHALL not abort an in-flight transaction.
REQ-029 The FSM SHALL wait on rom_ok with no timeout.

Reset
REQ-030 On rst_n low, SHALL asynchronously set state=IDLE, rom_cs=0, rom_addr=0, valid_a/b=0, tag_a/b=0, data_a/b=0, and last_served=B (so A wins the first tie).
REQ-031 During reset, cha_ok=chb_ok=0 and cha_dout=chb_dout=0x00.
REQ-032 Reset asserted mid-BUSY SHALL drop rom_cs immediately, with no fill.

Verification
REQ-033 Single miss: cha_cs=1, cha_addr=0x00010 -> rom_cs=1 and rom_addr=0x00010 next cycle; rom_ok=1 with rom_dout=0x5A three cycles later -> cha_ok=1, cha_dout=0x5A, rom_cs=0.
REQ-034 Hit: after REQ-033, hold cha_addr=0x00010 -> cha_ok=1 in the same cycle, and rom_cs stays 0.
REQ-035 Tie, round-robin: both channels miss in the same cycle right after reset -> A served, then B; a second simultaneous miss -> B served first.
REQ-036 Stale ok: rom_ok held high continuously -> the settle cycle is ignored, and the fill occurs on the second BUSY cycle exactly.
REQ-037 Invalidate: inval pulse while both channels hit -> cha_ok=chb_ok=0 next cycle, then refetch proceeds A then B; an inval coinciding with a fill -> that channel's valid stays 0.
REQ-038 Reset mid-transaction: rst_n low during BUSY_B -> rom_cs=0 immediately, chb_ok=0; after release, the request is re-issued as a fresh miss.
